ram_port_arbiter: RTL

- Shares the single DDR2 block port (ram_en/ram_write/ram_addr/256-bit block data/ram_rdy, as driven into ddr_ctrl) between two masters.
- Master 0 is cache_manage_unit (I/D miss fill and writeback). Master 1 is a boot/DMA copier that moves loader or frame data into main memory.
- Sequences one transaction at a time and grants round-robin or fixed priority.
- Holds the DDR request stable until ram_rdy, returns the block to the winner, and flags a hung controller through a watchdog.

---
 rtl/ram_port_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_port_arbiter
// Brief    : Shares the ddr_ctrl block port between two masters, one
//            transaction at a time, with a sticky hung-controller watchdog.
// Revision : 1.0
// ============================================================================
module ram_port_arbiter #(
  parameter int ADDR_WIDTH     = 30,
  parameter int BLOCK_WIDTH    = 256,
  parameter int PRIORITY_MODE  = 0,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   m0_en,
  input  logic                   m0_write,
  input  logic [ADDR_WIDTH-1:0]  m0_addr,
  input  logic [BLOCK_WIDTH-1:0] m0_wdata,
  output logic                   m0_rdy,
  output logic [BLOCK_WIDTH-1:0] m0_rdata,
  input  logic                   m1_en,
  input  logic                   m1_write,
  input  logic [ADDR_WIDTH-1:0]  m1_addr,
  input  logic [BLOCK_WIDTH-1:0] m1_wdata,
  output logic                   m1_rdy,
  output logic [BLOCK_WIDTH-1:0] m1_rdata,
  output logic                   ram_en,
  output logic                   ram_write,
  output logic [ADDR_WIDTH-1:0]  ram_addr,
  output logic [BLOCK_WIDTH-1:0] data_to_ram,
  input  logic                   ram_rdy,
  input  logic [BLOCK_WIDTH-1:0] block_in,
  output logic                   grant,
  output logic                   busy,
  output logic                   timeout_err
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_BUSY    = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  logic [1:0] state;
  logic       last_grant;
  logic       any_req;
  logic       winner;

  always_comb begin
    any_req = m0_en | m1_en;
    winner  = m1_en;
    if (m0_en && m1_en) begin
      winner = (PRIORITY_MODE != 0) ? 1'b0 : ~last_grant;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      last_grant  <= 1'b1;
      ram_en      <= 1'b0;
      ram_write   <= 1'b0;
      ram_addr    <= '0;
      data_to_ram <= '0;
      m0_rdy      <= 1'b0;
      m1_rdy      <= 1'b0;
      m0_rdata    <= '0;
      m1_rdata    <= '0;
      grant       <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            ram_en      <= 1'b1;
            busy        <= 1'b1;
            grant       <= winner;
            last_grant  <= winner;
            ram_write   <= winner ? m1_write : m0_write;
            ram_addr    <= winner ? m1_addr  : m0_addr;
            data_to_ram <= winner ? m1_wdata : m0_wdata;
            state       <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (ram_rdy) begin
            ram_en    <= 1'b0;
            ram_write <= 1'b0;
            // ram_write still holds the latched direction in this cycle
            if (!ram_write) begin
              if (grant) m1_rdata <= block_in;
              else       m0_rdata <= block_in;
            end
            if (grant) m1_rdy <= 1'b1;
            else       m0_rdy <= 1'b1;
            state <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          m0_rdy <= 1'b0;
          m1_rdy <= 1'b0;
          busy   <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_wdog
      localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
      localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);
      logic [CW-1:0] wd_cnt;
      logic          wd_err;

      // Counter saturates at LIMIT; the transaction itself is never aborted
      always_ff @(posedge clk) begin
        if (rst) begin
          wd_cnt <= '0;
          wd_err <= 1'b0;
        end else if (state == S_IDLE && any_req) begin
          wd_cnt <= '0;
        end else if (state == S_BUSY && !ram_rdy) begin
          if (wd_cnt == LIMIT) wd_err <= 1'b1;
          else                 wd_cnt <= wd_cnt + 1'b1;
        end
      end
      assign timeout_err = wd_err;
    end else begin : g_no_wdog
      assign timeout_err = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire
